mem_bist_master: RTL and testbench

- Synthesizable initiator for the valid/ready single-port memory interface: valid, wr_rd (1=write, 0=read), addr, wdata, rdata, ready.
- On start, writes a selected data pattern to every address 0..DEPTH-1, then reads each address back and compares against the regenerated pattern.
- Reports pass/fail, error count, first failing address and handshake timeout.
- Sits beside the memory block and replaces bench-driven write/read sweeps for memory self-test.

---
 rtl/mem_bist_master.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_bist_master.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bist_master.sv
// ----------------------------------------------------------------------------
// mem_bist_master
// Memory self-test initiator for a valid/ready single-port memory interface.
// On start it writes a selected pattern to every address 0..DEPTH-1, then
// reads every address back and compares it against the regenerated pattern.
// It reports pass/fail, mismatch count, first failing address and a
// handshake timeout.
//
// Ports
//   clk_i            clock, all logic on the rising edge
//   rst_i            synchronous active-high reset
//   start_i          begin a run (honoured only in IDLE or DONE)
//   pattern_sel_i    0=address, 1=LFSR, 2=checkerboard, 3=all-ones
//   valid_o          transfer request
//   wr_rd_o          1=write, 0=read
//   addr_o           transfer address
//   wdata_o          write data (zero during reads)
//   rdata_i          read data, valid when ready_i=1 on a read
//   ready_i          responder completes the current transfer
//   busy_o           high while sweeping (WRITE or READ)
//   done_o           high in DONE
//   pass_o           result, meaningful while done_o=1
//   err_count_o      number of read mismatches
//   first_err_addr_o address of the first mismatch
//   timeout_o        sticky handshake timeout flag for this run
// ----------------------------------------------------------------------------
module mem_bist_master #(
    parameter int          WIDTH      = 16,
    parameter int          DEPTH      = 512,
    parameter int          ADDR_WIDTH = $clog2(DEPTH),
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int          TIMEOUT    = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [1:0]            pattern_sel_i,
    output logic                  valid_o,
    output logic                  wr_rd_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [WIDTH-1:0]      wdata_o,
    input  logic [WIDTH-1:0]      rdata_i,
    input  logic                  ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [ADDR_WIDTH:0]   err_count_o,
    output logic [ADDR_WIDTH-1:0] first_err_addr_o,
    output logic                  timeout_o
);

    // An all-zero seed would lock the LFSR at zero.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam int          EW       = ADDR_WIDTH + 1;
    localparam int          WAIT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
    // The counter holds the number of stalled cycles already seen, so the
    // limit is hit on the stalled cycle that would bring it to TIMEOUT.
    localparam logic [WAIT_W-1:0]     WAIT_LIMIT = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // 16-bit Galois LFSR step, taps 0xB400 (right-shifting form).
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Data word for address a under pattern sel; lfsr is the LFSR value
    // associated with that address.
    function automatic logic [WIDTH-1:0] pattern(input logic [1:0]            sel,
                                                 input logic [ADDR_WIDTH-1:0] a,
                                                 input logic [15:0]           lfsr);
        logic [WIDTH-1:0] r;
        case (sel)
            2'd0:    r = WIDTH'(a);
            2'd1:    r = WIDTH'(lfsr);
            2'd2:    r = a[0] ? WIDTH'({(WIDTH/2){2'b10}}) : WIDTH'({(WIDTH/2){2'b01}});
            2'd3:    r = {WIDTH{1'b1}};
            default: r = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    state_e                state_q;
    logic [1:0]            pat_sel_q;
    logic [15:0]           lfsr_q;
    logic [WAIT_W-1:0]     wait_q;
    logic                  valid_q;
    logic                  wr_rd_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WIDTH-1:0]      wdata_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  pass_q;
    logic [EW-1:0]         err_count_q;
    logic [ADDR_WIDTH-1:0] first_err_q;
    logic                  timeout_q;

    logic                  hs_s;
    logic                  last_s;
    logic                  mismatch_s;
    logic [WIDTH-1:0]      exp_data_s;
    logic [WIDTH-1:0]      start_wdata_s;
    logic [15:0]           lfsr_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [WIDTH-1:0]      wdata_d;

    // Handshake detection, read compare and next-address/data generation.
    always_comb begin
        hs_s          = valid_q & ready_i;
        last_s        = (addr_q == LAST_ADDR);
        lfsr_d        = lfsr_step(lfsr_q);
        addr_d        = addr_q + ADDR_WIDTH'(1'b1);
        exp_data_s    = pattern(pat_sel_q, addr_q, lfsr_q);
        mismatch_s    = (rdata_i != exp_data_s);
        wdata_d       = pattern(pat_sel_q, addr_d, lfsr_d);
        start_wdata_s = pattern(pattern_sel_i, {ADDR_WIDTH{1'b0}}, SEED_EFF);
    end

    // Test sequencer: IDLE -> WRITE -> READ -> DONE, all outputs registered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            pat_sel_q   <= 2'd0;
            lfsr_q      <= SEED_EFF;
            wait_q      <= {WAIT_W{1'b0}};
            valid_q     <= 1'b0;
            wr_rd_q     <= 1'b0;
            addr_q      <= {ADDR_WIDTH{1'b0}};
            wdata_q     <= {WIDTH{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= {EW{1'b0}};
            first_err_q <= {ADDR_WIDTH{1'b0}};
            timeout_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        state_q     <= ST_WRITE;
                        pat_sel_q   <= pattern_sel_i;
                        lfsr_q      <= SEED_EFF;
                        wait_q      <= {WAIT_W{1'b0}};
                        err_count_q <= {EW{1'b0}};
                        first_err_q <= {ADDR_WIDTH{1'b0}};
                        timeout_q   <= 1'b0;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        busy_q      <= 1'b1;
                        valid_q     <= 1'b1;
                        wr_rd_q     <= 1'b1;
                        addr_q      <= {ADDR_WIDTH{1'b0}};
                        wdata_q     <= start_wdata_s;
                    end
                end
                ST_WRITE, ST_READ: begin
                    if (hs_s) begin
                        wait_q <= {WAIT_W{1'b0}};
                        if ((state_q == ST_READ) && mismatch_s) begin
                            // At most DEPTH mismatches, so EW bits never wrap.
                            err_count_q <= err_count_q + EW'(1'b1);
                            if (err_count_q == {EW{1'b0}}) begin
                                first_err_q <= addr_q;
                            end
                        end
                        if (last_s && (state_q == ST_WRITE)) begin
                            // Restart the LFSR so reads regenerate the written data.
                            state_q <= ST_READ;
                            lfsr_q  <= SEED_EFF;
                            addr_q  <= {ADDR_WIDTH{1'b0}};
                            wr_rd_q <= 1'b0;
                            wdata_q <= {WIDTH{1'b0}};
                        end else if (last_s) begin
                            state_q <= ST_DONE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_count_q == {EW{1'b0}}) && !mismatch_s && !timeout_q;
                        end else begin
                            addr_q  <= addr_d;
                            lfsr_q  <= lfsr_d;
                            wdata_q <= wr_rd_q ? wdata_d : {WIDTH{1'b0}};
                        end
                    end else if (wait_q == WAIT_LIMIT) begin
                        // Responder stalled too long: abandon the run.
                        state_q   <= ST_DONE;
                        timeout_q <= 1'b1;
                        valid_q   <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        pass_q    <= 1'b0;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1'b1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign valid_o          = valid_q;
    assign wr_rd_o          = wr_rd_q;
    assign addr_o           = addr_q;
    assign wdata_o          = wdata_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign err_count_o      = err_count_q;
    assign first_err_addr_o = first_err_q;
    assign timeout_o        = timeout_q;

endmodule

// File: tb/tb_mem_bist_master.sv
// ----------------------------------------------------------------------------
// tb_mem_bist_master
// Self-checking bench for mem_bist_master. A behavioural memory responder
// with selectable ready behaviour (always ready, 3 wait states, stall on
// write of address 17) and optional read bit-flips on addresses 5 and 300.
// Hand-computed write-data vectors are checked against logged write data.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_bist_master;

    localparam int WIDTH   = 16;
    localparam int DEPTH   = 512;
    localparam int AW      = 9;
    localparam int TIMEOUT = 255;

    logic          clk;
    logic          rst_i;
    logic          start_i;
    logic [1:0]    pattern_sel_i;
    logic          valid_o;
    logic          wr_rd_o;
    logic [AW-1:0] addr_o;
    logic [15:0]   wdata_o;
    logic [15:0]   rdata_i;
    logic          ready_i;
    logic          busy_o;
    logic          done_o;
    logic          pass_o;
    logic [AW:0]   err_count_o;
    logic [AW-1:0] first_err_addr_o;
    logic          timeout_o;

    mem_bist_master #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .SEED(16'hACE1), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .pattern_sel_i(pattern_sel_i),
        .valid_o(valid_o), .wr_rd_o(wr_rd_o), .addr_o(addr_o), .wdata_o(wdata_o),
        .rdata_i(rdata_i), .ready_i(ready_i), .busy_o(busy_o), .done_o(done_o),
        .pass_o(pass_o), .err_count_o(err_count_o), .first_err_addr_o(first_err_addr_o),
        .timeout_o(timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // ---------------- responder model ----------------
    int          rmode   = 0;      // 0 always ready, 1 three waits, 2 stall write@17
    bit          flip_en = 1'b0;
    int          wcnt    = 0;
    logic [15:0] mem  [0:DEPTH-1];
    logic [15:0] wlog [0:DEPTH-1];

    assign ready_i = (rmode == 0) ? 1'b1 :
                     (rmode == 1) ? (wcnt == 3) :
                     !(valid_o && wr_rd_o && (addr_o == 9'd17));
    assign rdata_i = mem[addr_o] ^
                     ((flip_en && !wr_rd_o && (addr_o == 9'd5 || addr_o == 9'd300)) ? 16'h0001 : 16'h0000);

    always @(posedge clk) begin
        if (valid_o && !ready_i) wcnt <= wcnt + 1;
        else                     wcnt <= 0;
    end

    int pcnt = 0;
    always @(posedge clk) pcnt++;

    // ---------------- protocol monitor (mid-cycle) ----------------
    int            hs_idx    = 0;
    int            mon_err   = 0;
    int            stall_cyc = 0;
    logic          pv, pr, pw, prst;
    logic [AW-1:0] pa;
    logic [15:0]   pd;

    always @(negedge clk) begin
        if (!rst_i && pv === 1'b1 && pr === 1'b0 && prst === 1'b0) begin
            if (valid_o) begin
                if (addr_o !== pa || wr_rd_o !== pw || wdata_o !== pd) mon_err++;
            end else if (!timeout_o) begin
                mon_err++;
            end
        end
        if (valid_o && !ready_i) stall_cyc++;
        if (valid_o && ready_i && !rst_i) begin
            if (addr_o !== AW'(hs_idx % DEPTH) || wr_rd_o !== (hs_idx < DEPTH)) mon_err++;
            if (wr_rd_o) begin
                mem[addr_o]  = wdata_o;
                wlog[addr_o] = wdata_o;
            end else if (wdata_o !== 16'h0000) begin
                mon_err++;
            end
            hs_idx++;
        end
        pv = valid_o; pr = ready_i; pw = wr_rd_o; pa = addr_o; pd = wdata_o; prst = rst_i;
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]  sel;
        int          addr;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    int t0 = 0;

    task automatic start_run(input logic [1:0] sel, input logic [15:0] exp_w0);
        @(posedge clk); #1;
        for (int i = 0; i < DEPTH; i++) wlog[i] = 'x;
        hs_idx = 0; mon_err = 0; stall_cyc = 0;
        start_i = 1'b1; pattern_sel_i = sel;
        @(posedge clk); #1;
        t0 = pcnt;
        start_i = 1'b0;
        @(negedge clk);
        chk("start_flags", 32'({valid_o, wr_rd_o, busy_o, done_o, pass_o, timeout_o}), 32'h38);
        chk("start_counts", 32'({err_count_o, first_err_addr_o}), 32'h0);
        chk("start_addr_data", 32'({addr_o, wdata_o}), 32'(exp_w0));
    endtask

    task automatic end_run(input int exp_cyc, input logic exp_pass, input int exp_err,
                           input int exp_first, input logic exp_to, input int exp_hs,
                           input logic [1:0] sel);
        for (int i = 0; i < 6000 && !done_o; i++) @(negedge clk);
        chk("done_cycle", 32'(pcnt - t0 + 1), 32'(exp_cyc));
        chk("done_flags", 32'({valid_o, busy_o, done_o, pass_o, timeout_o}),
            32'({1'b0, 1'b0, 1'b1, exp_pass, exp_to}));
        chk("err_count", 32'(err_count_o), 32'(exp_err));
        chk("first_err_addr", 32'(first_err_addr_o), 32'(exp_first));
        chk("handshakes", 32'(hs_idx), 32'(exp_hs));
        chk("protocol", 32'(mon_err), 32'd0);
        for (int i = 0; i < 16; i++) begin
            if (tbl[i].sel == sel)
                chk($sformatf("wdata_p%0d_a%0d", sel, tbl[i].addr), 32'(wlog[tbl[i].addr]), 32'(tbl[i].exp));
        end
        repeat (3) @(negedge clk);
        chk("done_hold", 32'({valid_o, done_o, pass_o, err_count_o}),
            32'({1'b0, 1'b1, exp_pass, 10'(exp_err)}));
    endtask

    task automatic wait_addr(input logic wr, input int a);
        bit ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (valid_o && wr_rd_o == wr && addr_o == AW'(a)) ok = 1'b1;
        end
        chk("reach_addr", 32'(ok), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{sel: 2'd0, addr: 0,   exp: 16'h0000};
        tbl[1]  = '{sel: 2'd0, addr: 5,   exp: 16'h0005};
        tbl[2]  = '{sel: 2'd0, addr: 300, exp: 16'h012C};
        tbl[3]  = '{sel: 2'd0, addr: 511, exp: 16'h01FF};
        tbl[4]  = '{sel: 2'd1, addr: 0,   exp: 16'hACE1};
        tbl[5]  = '{sel: 2'd1, addr: 1,   exp: 16'hE270};
        tbl[6]  = '{sel: 2'd1, addr: 2,   exp: 16'h7138};
        tbl[7]  = '{sel: 2'd1, addr: 5,   exp: 16'h0E27};
        tbl[8]  = '{sel: 2'd1, addr: 6,   exp: 16'hB313};
        tbl[9]  = '{sel: 2'd2, addr: 0,   exp: 16'h5555};
        tbl[10] = '{sel: 2'd2, addr: 1,   exp: 16'hAAAA};
        tbl[11] = '{sel: 2'd2, addr: 41,  exp: 16'hAAAA};
        tbl[12] = '{sel: 2'd2, addr: 510, exp: 16'h5555};
        tbl[13] = '{sel: 2'd2, addr: 511, exp: 16'hAAAA};
        tbl[14] = '{sel: 2'd3, addr: 0,   exp: 16'hFFFF};
        tbl[15] = '{sel: 2'd3, addr: 16,  exp: 16'hFFFF};

        rst_i = 1'b1; start_i = 1'b0; pattern_sel_i = 2'd0;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("reset_flags", 32'({valid_o, wr_rd_o, busy_o, done_o, pass_o, timeout_o}), 32'h0);
        chk("reset_data", 32'({addr_o, wdata_o}), 32'h0);
        chk("reset_counts", 32'({err_count_o, first_err_addr_o}), 32'h0);

        // 1: ideal responder, address pattern
        rmode = 0; flip_en = 1'b0;
        start_run(2'd0, 16'h0000);
        end_run(1025, 1'b1, 0, 0, 1'b0, 1024, 2'd0);

        // 2: read bit-flips at 5 and 300, LFSR pattern
        flip_en = 1'b1;
        start_run(2'd1, 16'hACE1);
        end_run(1025, 1'b0, 2, 5, 1'b0, 1024, 2'd1);
        flip_en = 1'b0;

        // 3: three wait states per transfer, checkerboard (start from DONE with errors)
        rmode = 1;
        start_run(2'd2, 16'h5555);
        end_run(4097, 1'b1, 0, 0, 1'b0, 1024, 2'd2);

        // 4: stall on write of address 17 -> timeout
        rmode = 2;
        start_run(2'd3, 16'hFFFF);
        end_run(273, 1'b0, 0, 0, 1'b1, 17, 2'd3);
        chk("stall_cycles", 32'(stall_cyc), 32'd255);

        // 5: reset during read of address 100, then a fresh run
        rmode = 0;
        start_run(2'd0, 16'h0000);
        wait_addr(1'b0, 100);
        #1 rst_i = 1'b1;
        @(posedge clk); #1 rst_i = 1'b0;
        @(negedge clk);
        chk("abort_flags", 32'({valid_o, wr_rd_o, busy_o, done_o, pass_o, timeout_o}), 32'h0);
        chk("abort_data", 32'({addr_o, wdata_o}), 32'h0);
        chk("abort_counts", 32'({err_count_o, first_err_addr_o}), 32'h0);
        repeat (5) @(negedge clk);
        chk("abort_idle", 32'({valid_o, busy_o, done_o}), 32'h0);
        chk("abort_handshakes", 32'(hs_idx), 32'd613);
        start_run(2'd0, 16'h0000);
        end_run(1025, 1'b1, 0, 0, 1'b0, 1024, 2'd0);

        // 6: start_i during the write sweep is ignored
        start_run(2'd2, 16'h5555);
        wait_addr(1'b1, 40);
        #1 start_i = 1'b1; pattern_sel_i = 2'd3;
        @(posedge clk); #1 start_i = 1'b0; pattern_sel_i = 2'd2;
        @(negedge clk);
        chk("ignored_start_addr", 32'({busy_o, addr_o, wdata_o}), 32'({1'b1, 9'd41, 16'hAAAA}));
        end_run(1025, 1'b1, 0, 0, 1'b0, 1024, 2'd2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
